// File: rtl/temp_sensor_debouncer.sv
// Synchronises and debounces raw temperature-threshold bits for the alarm decoder.
// Also provides level-change pulses, a settled flag and a saturating glitch counter.
module temp_sensor_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned NCH             = 2,
  parameter int unsigned GLITCH_W        = 8
) (
  input  logic                clk_2,
  input  logic                reset,
  input  logic [NCH-1:0]      raw_in,
  output logic [NCH-1:0]      temp_out,
  output logic [NCH-1:0]      changed,
  output logic                settled,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned ABORT_W = $clog2(NCH + 1);
  localparam int unsigned SUM_W   = GLITCH_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SUM_W-1:0] GLITCH_MAX = SUM_W'((2 ** GLITCH_W) - 1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  logic [NCH-1:0]      sync1;
  logic [NCH-1:0]      sync2;
  state_t              state_q [NCH];
  state_t              state_d [NCH];
  logic [CNT_W-1:0]    cnt_q   [NCH];
  logic [CNT_W-1:0]    cnt_d   [NCH];
  logic [NCH-1:0]      temp_d;
  logic [NCH-1:0]      changed_d;
  logic                settled_d;
  logic [ABORT_W-1:0]  aborts;
  logic [SUM_W-1:0]    glitch_sum;
  logic [GLITCH_W-1:0] glitch_d;

  // State register: synchroniser chain, per-channel FSMs and registered outputs
  always_ff @(posedge clk_2) begin
    if (reset) begin
      sync1        <= '0;
      sync2        <= '0;
      temp_out     <= '0;
      changed      <= '0;
      settled      <= 1'b1;
      glitch_count <= '0;
      for (int ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= STABLE;
        cnt_q[ch]   <= '0;
      end
    end else begin
      sync1        <= raw_in;
      sync2        <= sync1;
      temp_out     <= temp_d;
      changed      <= changed_d;
      settled      <= settled_d;
      glitch_count <= glitch_d;
      for (int ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
    end
  end

  // Next-state logic: each channel follows sync2 only after it has held for DEBOUNCE_CYCLES edges
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    temp_d     = temp_out;
    changed_d  = '0;
    settled_d  = 1'b1;
    aborts     = '0;
    glitch_sum = '0;
    glitch_d   = glitch_count;

    for (int ch = 0; ch < NCH; ch++) begin
      if (state_q[ch] == STABLE) begin
        if (sync2[ch] != temp_out[ch]) begin
          state_d[ch] = PENDING;
          cnt_d[ch]   = CNT_W'(1);
        end else begin
          cnt_d[ch] = '0;
        end
      end else begin
        if (sync2[ch] == temp_out[ch]) begin
          state_d[ch] = STABLE;
          cnt_d[ch]   = '0;
          aborts      = aborts + ABORT_W'(1);
        end else if (cnt_q[ch] == CNT_LAST) begin
          state_d[ch]   = STABLE;
          cnt_d[ch]     = '0;
          temp_d[ch]    = sync2[ch];
          changed_d[ch] = 1'b1;
        end else begin
          cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
        end
      end

      if (state_d[ch] == PENDING) begin
        settled_d = 1'b0;
      end
    end

    // One extra bit of headroom lets the clamp see any overflow from simultaneous aborts
    glitch_sum = {1'b0, glitch_count} + SUM_W'(aborts);
    if (glitch_sum > GLITCH_MAX) begin
      glitch_d = GLITCH_MAX[GLITCH_W-1:0];
    end else begin
      glitch_d = glitch_sum[GLITCH_W-1:0];
    end
  end

endmodule

// File: tb/tb_temp_sensor_debouncer.sv
// Scoreboard bench for temp_sensor_debouncer: stimulus queues expected snapshots and
// changed pulses; a negedge monitor pops and compares them against the DUT.
module tb_temp_sensor_debouncer;

  localparam int unsigned NCH = 2;
  localparam int unsigned GW  = 8;
  localparam int unsigned DB  = 4;

  logic           clk_2 = 1'b0;
  logic           reset;
  logic [NCH-1:0] raw_in;
  logic [NCH-1:0] temp_out;
  logic [NCH-1:0] changed;
  logic           settled;
  logic [GW-1:0]  glitch_count;

  typedef struct {
    int unsigned at;
    string       name;
    logic [1:0]  temp;
    logic [1:0]  chg;
    logic        stl;
    logic [7:0]  glitch;
  } snap_t;

  typedef struct {
    int unsigned at;
    logic [1:0]  chg;
    logic [1:0]  temp;
  } evt_t;

  snap_t       snap_q[$];
  evt_t        evt_q[$];
  int unsigned cyc    = 0;
  int unsigned base   = 0;
  int          checks = 0;
  int          errors = 0;

  temp_sensor_debouncer #(
    .DEBOUNCE_CYCLES(DB),
    .NCH            (NCH),
    .GLITCH_W       (GW)
  ) dut (
    .clk_2       (clk_2),
    .reset       (reset),
    .raw_in      (raw_in),
    .temp_out    (temp_out),
    .changed     (changed),
    .settled     (settled),
    .glitch_count(glitch_count)
  );

  always #5 clk_2 = ~clk_2;

  always @(posedge clk_2) cyc <= cyc + 1;

  // Monitor: compare due snapshots and every changed pulse the DUT presents
  always @(negedge clk_2) begin : monitor
    snap_t s;
    evt_t  e;
    while (snap_q.size() > 0 && snap_q[0].at <= cyc) begin
      s = snap_q.pop_front();
      checks++;
      if (s.at != cyc || temp_out !== s.temp || changed !== s.chg ||
          settled !== s.stl || glitch_count !== s.glitch) begin
        errors++;
        $display("FAIL %s cyc=%0d due=%0d: got temp=%b chg=%b settled=%b glitch=%0d, want temp=%b chg=%b settled=%b glitch=%0d",
                 s.name, cyc, s.at, temp_out, changed, settled, glitch_count,
                 s.temp, s.chg, s.stl, s.glitch);
      end
    end
    if (|changed) begin
      checks++;
      if (evt_q.size() == 0) begin
        errors++;
        $display("FAIL changed_unexpected cyc=%0d: got changed=%b temp=%b, want no pulse",
                 cyc, changed, temp_out);
      end else begin
        e = evt_q.pop_front();
        if (e.at != cyc || changed !== e.chg || temp_out !== e.temp) begin
          errors++;
          $display("FAIL changed_pulse cyc=%0d: got changed=%b temp=%b, want changed=%b temp=%b at cyc=%0d",
                   cyc, changed, temp_out, e.chg, e.temp, e.at);
        end
      end
    end else if (evt_q.size() > 0 && evt_q[0].at <= cyc) begin
      e = evt_q.pop_front();
      checks++;
      errors++;
      $display("FAIL changed_missing cyc=%0d: got changed=%b, want changed=%b at cyc=%0d",
               cyc, changed, e.chg, e.at);
    end
  end

  task automatic exp_snap(input int unsigned n, input string nm, input logic [1:0] t,
                          input logic [1:0] c, input logic st, input logic [7:0] g);
    snap_t s;
    s.at     = base + n;
    s.name   = nm;
    s.temp   = t;
    s.chg    = c;
    s.stl    = st;
    s.glitch = g;
    snap_q.push_back(s);
  endtask

  task automatic exp_evt(input int unsigned n, input logic [1:0] c, input logic [1:0] t);
    evt_t e;
    e.at   = base + n;
    e.chg  = c;
    e.temp = t;
    evt_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  task automatic drive(input logic [1:0] v);
    @(negedge clk_2);
    raw_in = v;
    base   = cyc;
  endtask

  initial begin
    int g;
    reset  = 1'b1;
    raw_in = 2'b11;

    // Reset held two edges with raw high; outputs must sit at reset values
    base = 0;
    exp_snap(1, "reset_e1", 2'b00, 2'b00, 1'b1, 8'd0);
    exp_snap(2, "reset_e2", 2'b00, 2'b00, 1'b1, 8'd0);
    wait_cycles(2);
    reset = 1'b0;
    base  = cyc;
    exp_snap(2, "t1_sync_only", 2'b00, 2'b00, 1'b1, 8'd0);
    exp_snap(5, "t1_pending",   2'b00, 2'b00, 1'b0, 8'd0);
    exp_snap(6, "t1_commit",    2'b11, 2'b11, 1'b1, 8'd0);
    exp_evt (6, 2'b11, 2'b11);
    exp_snap(7, "t1_after",     2'b11, 2'b00, 1'b1, 8'd0);
    wait_cycles(8);

    drive(2'b00);
    exp_snap(6, "t1_back_commit", 2'b00, 2'b11, 1'b1, 8'd0);
    exp_evt (6, 2'b11, 2'b00);
    exp_snap(7, "t1_back_after",  2'b00, 2'b00, 1'b1, 8'd0);
    wait_cycles(8);

    // Channel 1 only rises
    drive(2'b10);
    exp_snap(3, "t2_pend3",  2'b00, 2'b00, 1'b0, 8'd0);
    exp_snap(5, "t2_pend5",  2'b00, 2'b00, 1'b0, 8'd0);
    exp_snap(6, "t2_commit", 2'b10, 2'b10, 1'b1, 8'd0);
    exp_evt (6, 2'b10, 2'b10);
    exp_snap(7, "t2_after",  2'b10, 2'b00, 1'b1, 8'd0);
    wait_cycles(8);
    drive(2'b00);
    exp_snap(6, "t2_back_commit", 2'b00, 2'b10, 1'b1, 8'd0);
    exp_evt (6, 2'b10, 2'b00);
    wait_cycles(8);

    // Two-cycle pulse on channel 0 aborts once
    drive(2'b01);
    exp_snap(3, "t3_pend3", 2'b00, 2'b00, 1'b0, 8'd0);
    exp_snap(4, "t3_pend4", 2'b00, 2'b00, 1'b0, 8'd0);
    exp_snap(5, "t3_abort", 2'b00, 2'b00, 1'b1, 8'd1);
    exp_snap(8, "t3_hold",  2'b00, 2'b00, 1'b1, 8'd1);
    wait_cycles(2);
    raw_in = 2'b00;
    wait_cycles(7);

    // Reset while channel 1 is PENDING with cnt=2
    drive(2'b10);
    exp_snap(3, "t5_cnt1", 2'b00, 2'b00, 1'b0, 8'd1);
    exp_snap(4, "t5_cnt2", 2'b00, 2'b00, 1'b0, 8'd1);
    wait_cycles(4);
    reset  = 1'b1;
    raw_in = 2'b00;
    exp_snap(5, "t5_reset", 2'b00, 2'b00, 1'b1, 8'd0);
    wait_cycles(1);
    reset = 1'b0;
    exp_snap(10, "t5_quiet", 2'b00, 2'b00, 1'b1, 8'd0);
    wait_cycles(6);

    // Simultaneous two-cycle bursts on both channels drive the counter into saturation
    for (int k = 1; k <= 130; k++) begin
      drive(2'b11);
      g = 2 * (k - 1);
      if (g > 255) g = 255;
      exp_snap(3, "t4_pend", 2'b00, 2'b00, 1'b0, 8'(g));
      g = 2 * k;
      if (g > 255) g = 255;
      exp_snap(5, "t4_abort", 2'b00, 2'b00, 1'b1, 8'(g));
      wait_cycles(2);
      raw_in = 2'b00;
      wait_cycles(4);
    end

    // Both channels commit on the same edge
    drive(2'b11);
    exp_snap(5,  "t6_pend",   2'b00, 2'b00, 1'b0, 8'd255);
    exp_snap(6,  "t6_commit", 2'b11, 2'b11, 1'b1, 8'd255);
    exp_evt (6, 2'b11, 2'b11);
    exp_snap(7,  "t6_after",  2'b11, 2'b00, 1'b1, 8'd255);
    exp_snap(12, "t6_hold",   2'b11, 2'b00, 1'b1, 8'd255);
    wait_cycles(13);

    for (int i = 0; i < 100 && (snap_q.size() > 0 || evt_q.size() > 0); i++) begin
      @(negedge clk_2);
    end
    if (snap_q.size() > 0 || evt_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d snapshots and %0d pulses outstanding, want 0",
               snap_q.size(), evt_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
